// File: rtl/uart2_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | uart2_pkg                                                            |
// | Shared UART2 definitions: FSM encodings, word width, parity helper.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package uart2_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart2_state_t;

   function automatic logic parity_even(input logic [DATA_BITS-1:0] data);
      return ^data;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart2_rx_sync.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | uart2_rx_sync                                                        |
// | Two-flop synchroniser for the serial line plus falling-edge detect.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart2_rx_sync (
   input  logic clk_sis,
   input  logic rst_n,
   input  logic rx,
   output logic rx_s,
   output logic fall
);

   logic r_meta;
   logic r_sync;
   logic r_sync_d;

   // All stages reset high so an idle line never looks like a start edge.
   always_ff @(posedge clk_sis or negedge rst_n) begin
      if (!rst_n) begin
         r_meta   <= 1'b1;
         r_sync   <= 1'b1;
         r_sync_d <= 1'b1;
      end else begin
         r_meta   <= rx;
         r_sync   <= r_meta;
         r_sync_d <= r_sync;
      end
   end

   assign rx_s = r_sync;
   assign fall = r_sync_d & ~r_sync;

endmodule
`default_nettype wire

// File: rtl/uart2_rx.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | uart2_rx                                                             |
// | UART2 receiver: 8E1 frames, mid-bit sampling, valid/ready output.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart2_rx
   import uart2_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                 clk_sis,
   input  logic                 rst_n,
   input  logic                 rx2,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int                 c_cnt_w    = $clog2(CLKS_PER_BIT);
   localparam logic [c_cnt_w-1:0] c_cnt_half = c_cnt_w'(CLKS_PER_BIT/2 - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLKS_PER_BIT - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
   localparam logic [2:0]         c_bit_last = 3'(DATA_BITS - 1);

   uart2_state_t         r_state,   w_state_next;
   logic [c_cnt_w-1:0]   r_cnt,     w_cnt_next;
   logic [2:0]           r_bit_cnt, w_bit_cnt_next;
   logic [DATA_BITS-1:0] r_shift,   w_shift_next;
   logic                 r_par_bad, w_par_bad_next;
   logic                 w_rx_s;
   logic                 w_fall;
   logic                 w_tick;
   logic                 w_deliver;
   logic                 w_fr_bad;
   logic                 w_accept;

   uart2_rx_sync u_sync (
      .clk_sis (clk_sis),
      .rst_n   (rst_n),
      .rx      (rx2),
      .rx_s    (w_rx_s),
      .fall    (w_fall)
   );

   assign w_tick   = (r_cnt == c_cnt_last);
   assign w_accept = data_valid & data_ready;
   assign busy     = (r_state != IDLE);

   always_ff @(posedge clk_sis or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_par_bad <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_cnt     <= w_cnt_next;
         r_bit_cnt <= w_bit_cnt_next;
         r_shift   <= w_shift_next;
         r_par_bad <= w_par_bad_next;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_cnt_next     = r_cnt + c_cnt_one;
      w_bit_cnt_next = r_bit_cnt;
      w_shift_next   = r_shift;
      w_par_bad_next = r_par_bad;
      w_deliver      = 1'b0;
      w_fr_bad       = 1'b0;
      case (r_state)
         IDLE: begin
            w_cnt_next = '0;
            if (w_fall) w_state_next = START;
         end
         START: begin
            // Half a bit in: a line already back high was only a glitch.
            if (r_cnt == c_cnt_half) begin
               w_cnt_next     = '0;
               w_bit_cnt_next = '0;
               w_state_next   = w_rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (w_tick) begin
               w_cnt_next     = '0;
               w_shift_next   = {w_rx_s, r_shift[DATA_BITS-1:1]};
               w_bit_cnt_next = r_bit_cnt + 3'd1;
               if (r_bit_cnt == c_bit_last) w_state_next = PARITY;
            end
         end
         PARITY: begin
            if (w_tick) begin
               w_cnt_next     = '0;
               w_par_bad_next = w_rx_s ^ parity_even(r_shift);
               w_state_next   = STOP;
            end
         end
         STOP: begin
            if (w_tick) begin
               w_cnt_next   = '0;
               w_deliver    = 1'b1;
               w_fr_bad     = ~w_rx_s;
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // A word held unaccepted blocks delivery; the newcomer is dropped and flagged.
   always_ff @(posedge clk_sis or negedge rst_n) begin
      if (!rst_n) begin
         data_out   <= '0;
         data_valid <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else if (w_deliver) begin
         if (!data_valid || data_ready) begin
            data_out   <= r_shift;
            parity_err <= r_par_bad;
            frame_err  <= w_fr_bad;
            data_valid <= 1'b1;
            overrun    <= 1'b0;
         end else begin
            overrun    <= 1'b1;
         end
      end else if (w_accept) begin
         data_valid <= 1'b0;
         overrun    <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart2_rx.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_uart2_rx                                                          |
// | Scoreboard bench for uart2_rx driven by a 16 clk/bit line model.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_uart2_rx;

   localparam int CPB = 16;

   typedef struct packed {
      logic [7:0] d;
      logic       pe;
      logic       fe;
   } exp_t;

   logic       clk_sis = 1'b0;
   logic       rst_n   = 1'b0;
   logic       rx2     = 1'b1;
   logic       data_ready = 1'b1;
   logic [7:0] data_out;
   logic       data_valid;
   logic       parity_err;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   exp_t sb_q[$];
   int   n_tests  = 0;
   int   n_fail   = 0;
   int   n_words  = 0;
   int   valid_run = 0;
   int   last_run  = 0;

   uart2_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk_sis    (clk_sis),
      .rst_n      (rst_n),
      .rx2        (rx2),
      .data_out   (data_out),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .busy       (busy)
   );

   always #5 clk_sis = ~clk_sis;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: a word is presented when valid is high and the previous one
   // was either absent or accepted on this edge.
   always @(posedge clk_sis) begin
      logic pre_valid;
      logic pre_hs;
      exp_t e;
      pre_valid = data_valid;
      pre_hs    = data_valid & data_ready;
      #1;
      if (data_valid) valid_run++;
      else if (valid_run > 0) begin
         last_run  = valid_run;
         valid_run = 0;
      end
      if (rst_n && data_valid && (!pre_valid || pre_hs)) begin
         n_words++;
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_word: got 0x%0h, expected none", data_out);
         end else begin
            e = sb_q.pop_front();
            check("word_data", 32'(data_out), 32'(e.d));
            check("word_parity_err", 32'(parity_err), 32'(e.pe));
            check("word_frame_err", 32'(frame_err), 32'(e.fe));
         end
      end
   end

   task automatic drive_bit(input logic b);
      rx2 = b;
      repeat (CPB) @(negedge clk_sis);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      drive_bit(p);
      drive_bit(s);
   endtask

   task automatic idle_bits(input int n);
      rx2 = 1'b1;
      repeat (n * CPB) @(negedge clk_sis);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_data_out"},   32'(data_out),   32'h0);
      check({tag, "_data_valid"}, 32'(data_valid), 32'h0);
      check({tag, "_parity_err"}, 32'(parity_err), 32'h0);
      check({tag, "_frame_err"},  32'(frame_err),  32'h0);
      check({tag, "_overrun"},    32'(overrun),    32'h0);
      check({tag, "_busy"},       32'(busy),       32'h0);
   endtask

   initial begin
      int w0;
      repeat (3) @(negedge clk_sis);
      check_all_zero("reset");
      rst_n = 1'b1;
      idle_bits(2);

      // 1: clean frame, consumer always ready
      sb_q.push_back('{d: 8'hA5, pe: 1'b0, fe: 1'b0});
      send_frame(8'hA5, 1'b0, 1'b1);
      idle_bits(2);
      check("t1_valid_pulse_len", 32'(last_run), 32'd1);
      check("t1_busy_idle", 32'(busy), 32'h0);
      check("t1_valid_low", 32'(data_valid), 32'h0);

      // 2: wrong parity bit
      sb_q.push_back('{d: 8'h01, pe: 1'b1, fe: 1'b0});
      send_frame(8'h01, 1'b0, 1'b1);
      idle_bits(2);

      // 3: bad stop bit, line stays low afterwards
      w0 = n_words;
      sb_q.push_back('{d: 8'h3C, pe: 1'b0, fe: 1'b1});
      send_frame(8'h3C, 1'b0, 1'b0);
      repeat (20) drive_bit(1'b0);
      check("t3_one_word_low", 32'(n_words - w0), 32'd1);
      check("t3_busy_low_line", 32'(busy), 32'h0);
      idle_bits(2);
      check("t3_one_word_after", 32'(n_words - w0), 32'd1);

      // 4: short glitch on an idle line
      w0 = n_words;
      rx2 = 1'b0;
      repeat (5) @(negedge clk_sis);
      rx2 = 1'b1;
      check("t4_busy_in_start", 32'(busy), 32'h1);
      repeat (CPB) @(negedge clk_sis);
      check("t4_busy_cleared", 32'(busy), 32'h0);
      idle_bits(1);
      check("t4_no_word", 32'(n_words - w0), 32'd0);

      // 5: stalled consumer, second frame dropped
      data_ready = 1'b0;
      sb_q.push_back('{d: 8'h11, pe: 1'b0, fe: 1'b0});
      send_frame(8'h11, 1'b0, 1'b1);
      send_frame(8'h22, 1'b0, 1'b1);
      idle_bits(2);
      check("t5_held_data", 32'(data_out), 32'h11);
      check("t5_held_valid", 32'(data_valid), 32'h1);
      check("t5_overrun_set", 32'(overrun), 32'h1);
      data_ready = 1'b1;
      @(negedge clk_sis);
      data_ready = 1'b0;
      check("t5_valid_after_accept", 32'(data_valid), 32'h0);
      check("t5_overrun_cleared", 32'(overrun), 32'h0);
      check("t5_data_kept", 32'(data_out), 32'h11);
      repeat (2) @(negedge clk_sis);
      data_ready = 1'b1;

      // 6: reset in the middle of a frame
      drive_bit(1'b0);
      repeat (3) drive_bit(1'b1);
      check("t6_busy_midframe", 32'(busy), 32'h1);
      rst_n = 1'b0;
      #1;
      check_all_zero("t6_reset");
      rx2 = 1'b1;
      repeat (3) @(negedge clk_sis);
      check_all_zero("t6_reset_hold");
      rst_n = 1'b1;
      idle_bits(2);
      sb_q.push_back('{d: 8'h5A, pe: 1'b0, fe: 1'b0});
      send_frame(8'h5A, 1'b0, 1'b1);
      idle_bits(2);

      for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk_sis);
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
